// File: rtl/pipeline_stage_ctrl_if.sv
// rtl/pipeline_stage_ctrl_if.sv - upstream/downstream handshake bundle for pipeline_stage_ctrl
//
// Signals:
//   in_valid  : upstream offers a word to stage 0
//   in_ready  : controller accepts the upstream word this cycle
//   out_valid : last stage holds a word for downstream
//   out_ready : downstream takes the word this cycle
// Modports:
//   master : the environment side (drives in_valid/out_ready)
//   slave  : the controller side (drives in_ready/out_valid)

interface pipeline_stage_ctrl_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid
  );

  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid
  );
endinterface

// File: rtl/pipeline_stage_ctrl.sv
// rtl/pipeline_stage_ctrl.sv - valid/ready sequencer for a chain of stage buffers
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   hs            : handshake bundle (slave side): in_valid/in_ready, out_valid/out_ready
//   stall         : level, freezes all movement and FSM state
//   flush         : single-cycle discard of all stage contents
//   drain_req     : single-cycle request to empty the pipe with input blocked
//   drain_done    : one-cycle pulse when the drain has completed
//   stage_assign  : per-stage load enable (bit k loads stage buffer k)
//   stage_valid   : per-stage occupancy flags
//   occupancy     : number of occupied stages

module pipeline_stage_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stage_ctrl_if.slave  hs,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  drain_req,
  output logic                  drain_done,
  output logic [NUM_STAGES-1:0] stage_assign,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic [CNT_WIDTH-1:0]  occupancy
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [NUM_STAGES-1:0] v_q;
  logic [NUM_STAGES-1:0] v_d;
  logic [NUM_STAGES-1:0] ready;
  logic [NUM_STAGES-1:0] assign_c;
  logic [CNT_WIDTH-1:0]  occ_q;
  logic [CNT_WIDTH-1:0]  occ_d;
  logic                  move_en;
  logic                  accept_en;
  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  out_fire;

  // Reset is folded in here so that every combinational handshake output
  // is forced low while rst is high, not only after the first reset edge.
  assign move_en = !stall && !flush && !rst;

  // Bubble collapse: a stage can take a word if it is empty or if the
  // stage downstream of it is itself able to move on this cycle.
  always_comb begin
    ready = '0;
    ready[NUM_STAGES-1] = !v_q[NUM_STAGES-1] || hs.out_ready;
    for (int k = NUM_STAGES - 2; k >= 0; k--) begin
      ready[k] = !v_q[k] || ready[k+1];
    end
  end

  always_comb begin
    in_ready_c  = ready[0] && move_en && accept_en;
    out_valid_c = v_q[NUM_STAGES-1] && move_en;
    out_fire    = out_valid_c && hs.out_ready;
    assign_c    = '0;
    assign_c[0] = hs.in_valid && in_ready_c;
    for (int k = 1; k < NUM_STAGES; k++) begin
      assign_c[k] = v_q[k-1] && ready[k] && move_en;
    end
  end

  // A stage is loaded, else emptied when its word moves on, else held.
  // Under stall no assign or output fire happens, so everything holds.
  always_comb begin
    v_d = v_q;
    if (flush) begin
      v_d = '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (assign_c[k]) begin
          v_d[k] = 1'b1;
        end else if (k == NUM_STAGES - 1) begin
          if (out_fire) v_d[k] = 1'b0;
        end else if (assign_c[k+1]) begin
          v_d[k] = 1'b0;
        end
      end
    end
  end

  // Occupancy is registered from the next-state flags so it always
  // matches the popcount of stage_valid in the same cycle.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      occ_d = occ_d + CNT_WIDTH'(v_d[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      occ_q <= '0;
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Flush wins over everything and returns to RUN
  // without passing DONE; stall freezes the state.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_RUN;
    end else if (!stall) begin
      case (state_q)
        ST_RUN:   if (drain_req) state_d = ST_DRAIN;
        ST_DRAIN: if (v_q == '0) state_d = ST_DONE;
        ST_DONE:  state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    accept_en  = (state_q == ST_RUN);
    drain_done = (state_q == ST_DONE) && !rst;
  end

  assign hs.in_ready   = in_ready_c;
  assign hs.out_valid  = out_valid_c;
  assign stage_assign  = assign_c;
  assign stage_valid   = v_q;
  assign occupancy     = occ_q;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// tb/tb_pipeline_stage_ctrl.sv - directed self-checking bench for pipeline_stage_ctrl

module tb_pipeline_stage_ctrl;
  logic       clk;
  logic       rst;
  logic       stall;
  logic       flush;
  logic       drain_req;
  logic       drain_done;
  logic [3:0] stage_assign;
  logic [3:0] stage_valid;
  logic [4:0] occupancy;
  int         checks;
  int         errors;

  pipeline_stage_ctrl_if psif ();

  pipeline_stage_ctrl #(.NUM_STAGES(4), .CNT_WIDTH(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .hs           (psif.slave),
    .stall        (stall),
    .flush        (flush),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .stage_assign (stage_assign),
    .stage_valid  (stage_valid),
    .occupancy    (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; drain_req = 1'b0;
    psif.in_valid = 1'b0; psif.out_ready = 1'b0;
    tick(); tick();

    // Reset overrides live inputs
    psif.in_valid = 1'b1; psif.out_ready = 1'b1; drain_req = 1'b1; flush = 1'b1; stall = 1'b1;
    settle();
    chk("rst_in_ready", psif.in_ready, 0);
    chk("rst_out_valid", psif.out_valid, 0);
    chk("rst_assign", stage_assign, 4'b0000);
    chk("rst_valid", stage_valid, 4'b0000);
    chk("rst_occ", occupancy, 0);
    chk("rst_done", drain_done, 0);

    // Single word walks through all four stages
    tick();
    rst = 1'b0; drain_req = 1'b0; flush = 1'b0; stall = 1'b0;
    psif.in_valid = 1'b1; psif.out_ready = 1'b1;
    settle();
    chk("walk_in_ready", psif.in_ready, 1);
    chk("walk_a0", stage_assign, 4'b0001);
    tick(); psif.in_valid = 1'b0; settle();
    chk("walk_a1", stage_assign, 4'b0010);
    chk("walk_v1", stage_valid, 4'b0001);
    chk("walk_occ1", occupancy, 1);
    tick(); settle();
    chk("walk_a2", stage_assign, 4'b0100);
    tick(); settle();
    chk("walk_a3", stage_assign, 4'b1000);
    chk("walk_ov_early", psif.out_valid, 0);
    tick(); settle();
    chk("walk_out_valid", psif.out_valid, 1);
    chk("walk_v4", stage_valid, 4'b1000);
    tick(); settle();
    chk("walk_empty", stage_valid, 4'b0000);
    chk("walk_occ0", occupancy, 0);

    // Fill with backpressure
    psif.in_valid = 1'b1; psif.out_ready = 1'b0;
    tick(); settle();
    chk("fill_occ1", occupancy, 1);
    chk("fill_a2", stage_assign, 4'b0011);
    tick(); settle();
    chk("fill_occ2", occupancy, 2);
    tick(); settle();
    chk("fill_occ3", occupancy, 3);
    tick(); settle();
    chk("fill_occ4", occupancy, 4);
    chk("fill_in_ready", psif.in_ready, 0);
    chk("fill_assign0", stage_assign, 4'b0000);
    psif.out_ready = 1'b1; settle();
    chk("pulse_out_valid", psif.out_valid, 1);
    chk("pulse_in_ready", psif.in_ready, 1);
    chk("pulse_assign", stage_assign, 4'b1111);
    tick(); psif.out_ready = 1'b0; settle();
    chk("pulse_occ", occupancy, 4);
    chk("pulse_valid", stage_valid, 4'b1111);
    chk("pulse_in_ready_after", psif.in_ready, 0);

    // Stall on a full pipe
    stall = 1'b1; psif.in_valid = 1'b1; psif.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_in_ready", psif.in_ready, 0);
      chk("stall_out_valid", psif.out_valid, 0);
      chk("stall_assign", stage_assign, 4'b0000);
      chk("stall_valid", stage_valid, 4'b1111);
      chk("stall_occ", occupancy, 4);
      tick();
    end

    // Flush a full pipe
    stall = 1'b0; flush = 1'b1;
    settle();
    chk("flush_assign", stage_assign, 4'b0000);
    chk("flush_out_valid", psif.out_valid, 0);
    chk("flush_in_ready", psif.in_ready, 0);
    tick(); flush = 1'b0; psif.in_valid = 1'b0; psif.out_ready = 1'b0; settle();
    chk("flush_valid", stage_valid, 4'b0000);
    chk("flush_occ", occupancy, 0);
    chk("flush_done", drain_done, 0);

    // Drain from occupancy 3
    psif.in_valid = 1'b1;
    tick(); tick(); tick();
    psif.in_valid = 1'b0; drain_req = 1'b1; psif.out_ready = 1'b1; settle();
    chk("drain_occ3", occupancy, 3);
    chk("drain_req_in_ready", psif.in_ready, 1);
    tick(); drain_req = 1'b0; psif.in_valid = 1'b1; settle();
    chk("drain_block", psif.in_ready, 0);
    chk("drain_assign0", stage_assign[0], 0);
    chk("drain_occ3b", occupancy, 3);
    tick(); settle();
    chk("drain_occ2", occupancy, 2);
    tick(); settle();
    chk("drain_occ1", occupancy, 1);
    tick(); settle();
    chk("drain_occ0", occupancy, 0);
    chk("drain_not_done_yet", drain_done, 0);
    tick(); settle();
    chk("drain_done", drain_done, 1);
    chk("drain_done_in_ready", psif.in_ready, 0);
    tick(); psif.in_valid = 1'b0; settle();
    chk("drain_done_off", drain_done, 0);
    chk("drain_resume", psif.in_ready, 1);

    // Drain of an empty pipe, with repeated requests ignored
    drain_req = 1'b1;
    tick(); settle();
    chk("edrain_in_ready", psif.in_ready, 0);
    chk("edrain_done0", drain_done, 0);
    tick(); settle();
    chk("edrain_done1", drain_done, 1);
    tick(); drain_req = 1'b0; settle();
    chk("edrain_ignore_run", psif.in_ready, 1);
    chk("edrain_done2", drain_done, 0);

    // Reset in the middle of a drain
    psif.in_valid = 1'b1; psif.out_ready = 1'b0;
    tick(); tick();
    psif.in_valid = 1'b0; drain_req = 1'b1; settle();
    chk("rdrain_occ2", occupancy, 2);
    tick(); drain_req = 1'b0; rst = 1'b1; settle();
    chk("rdrain_rst_in_ready", psif.in_ready, 0);
    chk("rdrain_rst_assign", stage_assign, 4'b0000);
    chk("rdrain_rst_done", drain_done, 0);
    tick(); rst = 1'b0; settle();
    chk("rdrain_valid", stage_valid, 4'b0000);
    chk("rdrain_occ", occupancy, 0);
    chk("rdrain_run", psif.in_ready, 1);
    chk("rdrain_done_a", drain_done, 0);
    tick(); settle();
    chk("rdrain_done_b", drain_done, 0);
    tick(); settle();
    chk("rdrain_done_c", drain_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
